// File: rtl/mmcm_phase_sequencer_if.sv
// Command, MMCM phase-shift and status signals for mmcm_phase_sequencer.
// The master side is the surrounding logic (host plus MMCMs); the slave side is the sequencer.
interface mmcm_phase_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int POS_W  = 9,
    parameter int CMD_W  = 16,
    parameter int CH_W   = 1
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CH_W-1:0]         cmd_ch;
    logic                    cmd_rel;
    logic [CMD_W-1:0]        cmd_value;
    logic [NUM_CH-1:0]       ps_en;
    logic [NUM_CH-1:0]       ps_incdec;
    logic [NUM_CH-1:0]       ps_done;
    logic [NUM_CH-1:0]       locked;
    logic [NUM_CH*POS_W-1:0] pos_flat;
    logic                    busy;
    logic                    done_pulse;
    logic [1:0]              status;

    modport master (
        output cmd_valid, cmd_ch, cmd_rel, cmd_value, ps_done, locked,
        input  cmd_ready, ps_en, ps_incdec, pos_flat, busy, done_pulse, status
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_rel, cmd_value, ps_done, locked,
        output cmd_ready, ps_en, ps_incdec, pos_flat, busy, done_pulse, status
    );
endinterface

// File: rtl/mmcm_phase_sequencer.sv
// Drives MMCM fine phase shift (PSEN/PSINCDEC/PSDONE) for several channels, one command at a time,
// moving along the shortest wrapped path and tracking each channel's position in fine steps.
module mmcm_phase_sequencer #(
    parameter int NUM_CH      = 2,
    parameter int WRAP_STEPS  = 280,
    parameter int CMD_W       = 16,
    parameter int TIMEOUT_CYC = 64,
    localparam int POS_W      = $clog2(WRAP_STEPS),
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mmcm_phase_sequencer_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_RANGE   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, DONE} state_t;

    state_t                        state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic                          rel_q, rel_d;
    logic [CMD_W-1:0]              value_q, value_d;
    logic                          dir_q, dir_d;
    logic [POS_W-1:0]              steps_q, steps_d;
    logic [TMO_W-1:0]              tmo_q, tmo_d;
    logic [1:0]                    status_q, status_d;

    logic [NUM_CH-1:0][POS_W-1:0]  pos_all;
    logic                          ch_ok;
    logic [CH_W-1:0]               ch_idx;
    logic                          lock_ch;
    logic                          done_ch;
    logic [POS_W-1:0]              pos_cur;
    logic                          step_en;
    logic                          issue_fire;
    logic                          range_err;
    int                            val_s;
    int                            tgt;
    int                            fwd;

    // Out-of-range channel numbers are masked to 0 so lookups stay in bounds; CALC rejects them anyway.
    assign ch_ok   = int'(ch_q) < NUM_CH;
    assign ch_idx  = ch_ok ? ch_q : '0;
    assign lock_ch = bus.locked[ch_idx];
    assign done_ch = bus.ps_done[ch_idx];
    assign pos_cur = pos_all[ch_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            rel_q    <= 1'b0;
            value_q  <= '0;
            dir_q    <= 1'b0;
            steps_q  <= '0;
            tmo_q    <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            rel_q    <= rel_d;
            value_q  <= value_d;
            dir_q    <= dir_d;
            steps_q  <= steps_d;
            tmo_q    <= tmo_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rel_d     = rel_q;
        value_d   = value_q;
        dir_d     = dir_q;
        steps_d   = steps_q;
        tmo_d     = tmo_q;
        status_d  = status_q;
        step_en   = 1'b0;

        // Relative deltas are bounded below one period, so a single wrap correction suffices.
        val_s = int'($signed(value_q));
        if (rel_q) begin
            tgt = int'(pos_cur) + val_s;
            if (tgt < 0)
                tgt = tgt + WRAP_STEPS;
            else if (tgt >= WRAP_STEPS)
                tgt = tgt - WRAP_STEPS;
        end else begin
            tgt = val_s;
        end
        fwd = tgt - int'(pos_cur);
        if (fwd < 0)
            fwd = fwd + WRAP_STEPS;
        range_err = !ch_ok || !lock_ch ||
                    (rel_q ? (val_s >= WRAP_STEPS || val_s <= -WRAP_STEPS)
                           : (val_s < 0 || val_s > WRAP_STEPS - 1));

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    ch_d    = bus.cmd_ch;
                    rel_d   = bus.cmd_rel;
                    value_d = bus.cmd_value;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (range_err) begin
                    status_d = ST_RANGE;
                    state_d  = DONE;
                end else if (fwd == 0) begin
                    status_d = ST_OK;
                    state_d  = DONE;
                end else if (fwd <= WRAP_STEPS / 2) begin
                    dir_d   = 1'b1;
                    steps_d = POS_W'(fwd);
                    state_d = ISSUE;
                end else begin
                    dir_d   = 1'b0;
                    steps_d = POS_W'(WRAP_STEPS - fwd);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!lock_ch) begin
                    status_d = ST_ABORT;
                    state_d  = DONE;
                end else begin
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Lock loss outranks PSDONE, which in turn outranks the timeout terminal count.
                if (!lock_ch) begin
                    status_d = ST_ABORT;
                    state_d  = DONE;
                end else if (done_ch) begin
                    step_en = 1'b1;
                    if (steps_q == POS_W'(1)) begin
                        status_d = ST_OK;
                        state_d  = DONE;
                    end else begin
                        steps_d = steps_q - 1'b1;
                        state_d = ISSUE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    status_d = ST_TIMEOUT;
                    state_d  = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by rst combinationally so a reset drops PSEN in the very cycle it is asserted.
    assign issue_fire = (state_q == ISSUE) && lock_ch && !rst;

    always_comb begin
        bus.ps_en     = '0;
        bus.ps_incdec = '0;
        if (issue_fire) begin
            bus.ps_en[ch_idx]     = 1'b1;
            bus.ps_incdec[ch_idx] = dir_q;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE) && !rst;
    assign bus.busy       = (state_q != IDLE) && !rst;
    assign bus.done_pulse = (state_q == DONE) && !rst;
    assign bus.status     = bus.done_pulse ? status_q : 2'd0;
    assign bus.pos_flat   = pos_all;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [POS_W-1:0] pos_q;

        // An MMCM that loses lock is reset and forgets its phase offset.
        always_ff @(posedge clk) begin
            if (rst) begin
                pos_q <= '0;
            end else if (!bus.locked[gi]) begin
                pos_q <= '0;
            end else if (step_en && (ch_idx == CH_W'(gi))) begin
                if (dir_q)
                    pos_q <= (pos_q == POS_W'(WRAP_STEPS - 1)) ? '0 : pos_q + 1'b1;
                else
                    pos_q <= (pos_q == '0) ? POS_W'(WRAP_STEPS - 1) : pos_q - 1'b1;
            end
        end

        assign pos_all[gi] = pos_q;
    end
endmodule
